tracker_axis_sequencer: RTL and testbench
=========================================

Name: tracker_axis_sequencer

Overview:
Parametrised two-axis (theta/phi) motor sequencer for the solar tracker. It replaces the fixed single-pass controller with a registered state machine that adds:
- sign-safe (W+1)-bit error arithmetic
- a settle filter before an axis counts as aligned
- dead time on direction reversal
- a per-move timeout fault
- configurable phi wrap-around
It sits between the photoresistor/encoder front end and the motor drivers.

Parameters:
W, 16, width of sensor, target and position inputs
DEADBAND, 5, in-band tolerance: |a-b| <= DEADBAND means aligned
HALF_TURN, 180, phi shortest-path threshold
FULL_TURN, 360, phi modulus; phi inputs are in [0, FULL_TURN-1]
SETTLE_CYCLES, 4, consecutive in-band cycles before an axis is declared settled
REVERSE_GAP, 2, idle cycles inserted when an axis reverses direction
TIMEOUT_CYCLES, 1000000, maximum cycles in one MOVE state before fault

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
enable  in  1  1 = run; 0 = outputs idle, FSM to IDLE
mode  in  2  2'b01 = manual; any other value = automatic
clear_fault  in  1  one-cycle pulse that leaves FAULT
r_v1, r_v2  in  W  vertical photoresistor pair (automatic theta)
r_h1, r_h2  in  W  horizontal photoresistor pair (automatic phi)
theta_target, theta_actual  in  W  manual theta setpoint / encoder
phi_target, phi_actual  in  W  manual phi setpoint / encoder
theta_pos, theta_neg  out  1  theta motor drive, horario/antihorario
phi_pos, phi_neg  out  1  phi motor drive, horario/antihorario
active_axis  out  1  0 = theta, 1 = phi
aligned  out  1  both axes settled in the current mode
timeout_err  out  1  sticky fault flag
state  out  3  FSM state encoding, for debug

Behaviour:
- Reset (rst=0, asynchronous):
  - all drive outputs 0, aligned=0, timeout_err=0, state=IDLE, active_axis=0
  - all counters 0
  - reset may arrive at any cycle; no drive output glitches high afterwards
- Outputs are registered: a drive output reflects inputs sampled on the previous rising edge (1-cycle latency).
- Drive invariants, every cycle:
  - pos and neg of one axis are never both 1
  - only the axis equal to active_axis may drive; the other axis is 0
- States: IDLE(0), MOVE_A(1), SETTLE_A(2), MOVE_B(3), SETTLE_B(4), ALIGNED(5), GAP(6), FAULT(7).
- Axis order:
  - automatic: A=theta, B=phi
  - manual: A=phi, B=theta
- Error arithmetic: all differences computed sign-extended to W+1 bits; no unsigned wrap. In-band means |e| <= DEADBAND.
- Direction rules:
  - automatic, per pair: r1>r2 -> pos; r1<r2 -> neg
  - manual theta, d = actual - target: d>0 -> pos; d<0 -> neg
  - manual phi, d = actual - target: d>0 and d<=HALF_TURN -> pos; d>HALF_TURN -> neg; d<0 and -d<=HALF_TURN -> neg; -d>HALF_TURN -> pos
- State transitions:
  - IDLE -> MOVE_A when enable=1
  - MOVE_x: drive the axis per the direction rule.
    - in-band -> SETTLE_x with drive 0 and settle counter = 1
    - requested direction opposite to the last driven direction -> GAP; drive 0 for REVERSE_GAP cycles, then return to MOVE_x
  - SETTLE_x: drive 0.
    - out-of-band -> MOVE_x, counter cleared
    - counter reaches SETTLE_CYCLES -> next state (SETTLE_A -> MOVE_B; SETTLE_B -> ALIGNED)
  - ALIGNED: aligned=1, no drive. Both axes monitored; either out-of-band -> MOVE_A and aligned=0 on the next cycle.
  - Timeout: counter runs only in MOVE_x and GAP, clears on entry to MOVE_x from SETTLE or another axis. Reaching TIMEOUT_CYCLES -> FAULT.
  - FAULT: drive 0, timeout_err=1. Leaves to IDLE only on clear_fault=1 (timeout_err cleared) or reset.
- Mode change (manual/automatic decode differs from the previous cycle), outside FAULT:
  - drive 0 on the next cycle
  - go to MOVE_A of the new mode; settle, gap and timeout counters cleared; aligned=0
- enable=0 in any state except FAULT -> IDLE next cycle, drive 0. FAULT is held regardless of enable.
- Boundary cases:
  - |e| == DEADBAND counts as in-band
  - phi d == HALF_TURN drives pos
  - equal sensors (e=0) count as in-band

Test Plan:
- Automatic theta, r_v1=300, r_v2=100; r_v1 stepped to 102 after 10 cycles -> theta_pos=1 from cycle 1; 0 once in-band; SETTLE 4 cycles, then active_axis=1.
- Manual phi wrap, phi_actual=10, phi_target=350 (d=-340) -> phi_pos=1 (shortest path). With phi_actual=200, phi_target=20 (d=180) -> phi_pos=1.
- Reversal, automatic theta driving pos, then r_v1<r_v2 by 50 -> theta_pos=0, theta_neg=0 for 2 cycles, then theta_neg=1.
- Timeout, TIMEOUT_CYCLES=20, manual theta error held at 100 -> FAULT after 20 cycles; timeout_err=1 and all drives 0 until clear_fault, then state=IDLE.
- Both axes in-band -> aligned=1. Perturb r_h1 by +40 -> aligned=0 and state=MOVE_A next cycle; theta re-settles before phi is driven.
- rst driven low asynchronously mid-MOVE_B with phi_neg=1 -> phi_neg=0 immediately. Mode 00 -> 01 mid-move -> 1 idle cycle, then MOVE_A on phi.

Source files
------------

// File: rtl/tracker_axis_sequencer.sv
// ============================================================================
// Module  : tracker_axis_sequencer
// Brief   : Two-axis (theta/phi) solar tracker motor sequencer with settle,
//           reversal dead time, move timeout and phi wrap-around.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tracker_axis_sequencer #(
  parameter int W              = 16,
  parameter int DEADBAND       = 5,
  parameter int HALF_TURN      = 180,
  parameter int FULL_TURN      = 360,
  parameter int SETTLE_CYCLES  = 4,
  parameter int REVERSE_GAP    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [1:0]   mode,
  input  logic         clear_fault,
  input  logic [W-1:0] r_v1,
  input  logic [W-1:0] r_v2,
  input  logic [W-1:0] r_h1,
  input  logic [W-1:0] r_h2,
  input  logic [W-1:0] theta_target,
  input  logic [W-1:0] theta_actual,
  input  logic [W-1:0] phi_target,
  input  logic [W-1:0] phi_actual,
  output logic         theta_pos,
  output logic         theta_neg,
  output logic         phi_pos,
  output logic         phi_neg,
  output logic         active_axis,
  output logic         aligned,
  output logic         timeout_err,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MOVE_A   = 3'd1,
    S_SETTLE_A = 3'd2,
    S_MOVE_B   = 3'd3,
    S_SETTLE_B = 3'd4,
    S_ALIGNED  = 3'd5,
    S_GAP      = 3'd6,
    S_FAULT    = 3'd7
  } state_t;

  localparam int SW = $clog2(SETTLE_CYCLES + 2);
  localparam int GW = $clog2(REVERSE_GAP + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

  localparam logic [W:0]    DB       = (W+1)'(DEADBAND);
  localparam logic [W:0]    HT       = (W+1)'(HALF_TURN);
  localparam logic [W:0]    FT       = (W+1)'(FULL_TURN);
  localparam logic [SW-1:0] SETTLE_N = SW'(SETTLE_CYCLES);
  localparam logic [GW-1:0] GAP_N    = GW'(REVERSE_GAP);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t        st;
  logic [SW-1:0] settle_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;
  logic          prev_manual;
  logic          last_valid;
  logic          last_neg;

  // Zero-extend both operands so the difference can never wrap.
  function automatic logic signed [W:0] diff(input logic [W-1:0] a, input logic [W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic [W:0] mag(input logic signed [W:0] e);
    logic [W:0] m;
    m = e[W] ? $unsigned(-e) : $unsigned(e);
    return m;
  endfunction

  logic              manual;
  logic              axis_a;
  logic              on_b;
  logic signed [W:0] theta_e;
  logic signed [W:0] phi_e;
  logic [W:0]        phi_m;
  logic [W:0]        phi_dist;
  logic              phi_wrap;
  logic              theta_in, theta_p, theta_n;
  logic              phi_in, phi_p, phi_n;
  logic              cur_in, cur_p, cur_n;
  logic              reverse;
  logic              gap_done;
  logic              timed_out;

  assign manual   = (mode == 2'b01);
  assign axis_a   = manual;
  assign on_b     = (active_axis != axis_a);

  assign theta_e  = manual ? diff(theta_actual, theta_target) : diff(r_v1, r_v2);
  assign theta_in = (mag(theta_e) <= DB);
  assign theta_p  = !theta_in && !theta_e[W];
  assign theta_n  = !theta_in && theta_e[W];

  // Manual phi takes the shorter way round when |d| exceeds half a turn.
  assign phi_e    = manual ? diff(phi_actual, phi_target) : diff(r_h1, r_h2);
  assign phi_m    = mag(phi_e);
  assign phi_wrap = manual && (phi_m > HT);
  assign phi_dist = phi_wrap ? (FT - phi_m) : phi_m;
  assign phi_in   = (phi_dist <= DB);
  assign phi_p    = !phi_in && (phi_e[W] == phi_wrap);
  assign phi_n    = !phi_in && (phi_e[W] != phi_wrap);

  assign cur_in    = active_axis ? phi_in : theta_in;
  assign cur_p     = active_axis ? phi_p  : theta_p;
  assign cur_n     = active_axis ? phi_n  : theta_n;
  assign reverse   = last_valid && (REVERSE_GAP > 0) && (last_neg ? cur_p : cur_n);
  assign gap_done  = (gap_cnt >= GAP_N);
  assign timed_out = (to_cnt >= TO_LAST);

  assign state = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= S_IDLE;
      theta_pos   <= 1'b0;
      theta_neg   <= 1'b0;
      phi_pos     <= 1'b0;
      phi_neg     <= 1'b0;
      active_axis <= 1'b0;
      aligned     <= 1'b0;
      timeout_err <= 1'b0;
      settle_cnt  <= '0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      prev_manual <= 1'b0;
      last_valid  <= 1'b0;
      last_neg    <= 1'b0;
    end else begin
      theta_pos   <= 1'b0;
      theta_neg   <= 1'b0;
      phi_pos     <= 1'b0;
      phi_neg     <= 1'b0;
      prev_manual <= manual;
      if (st == S_FAULT) begin
        if (clear_fault) begin
          st          <= S_IDLE;
          timeout_err <= 1'b0;
        end
      end else if (!enable) begin
        st         <= S_IDLE;
        aligned    <= 1'b0;
        settle_cnt <= '0;
        gap_cnt    <= '0;
        to_cnt     <= '0;
        last_valid <= 1'b0;
      end else if (manual != prev_manual) begin
        st          <= S_MOVE_A;
        active_axis <= manual;
        aligned     <= 1'b0;
        settle_cnt  <= '0;
        gap_cnt     <= '0;
        to_cnt      <= '0;
        last_valid  <= 1'b0;
      end else begin
        unique case (st)
          S_IDLE: begin
            st          <= S_MOVE_A;
            active_axis <= axis_a;
            to_cnt      <= '0;
            last_valid  <= 1'b0;
          end
          S_MOVE_A, S_MOVE_B, S_GAP: begin
            if (timed_out) begin
              st          <= S_FAULT;
              timeout_err <= 1'b1;
              last_valid  <= 1'b0;
            end else if (st == S_GAP && !gap_done) begin
              gap_cnt <= gap_cnt + 1'b1;
              to_cnt  <= to_cnt + 1'b1;
            end else if (cur_in) begin
              st         <= on_b ? S_SETTLE_B : S_SETTLE_A;
              settle_cnt <= SW'(1);
              last_valid <= 1'b0;
            end else if (reverse) begin
              st         <= S_GAP;
              gap_cnt    <= GW'(1);
              to_cnt     <= to_cnt + 1'b1;
              last_valid <= 1'b0;
            end else begin
              st         <= on_b ? S_MOVE_B : S_MOVE_A;
              last_valid <= 1'b1;
              last_neg   <= cur_n;
              to_cnt     <= to_cnt + 1'b1;
              if (active_axis) begin
                phi_pos <= cur_p;
                phi_neg <= cur_n;
              end else begin
                theta_pos <= cur_p;
                theta_neg <= cur_n;
              end
            end
          end
          S_SETTLE_A, S_SETTLE_B: begin
            if (!cur_in) begin
              st         <= on_b ? S_MOVE_B : S_MOVE_A;
              settle_cnt <= '0;
              to_cnt     <= '0;
            end else if (settle_cnt >= SETTLE_N) begin
              settle_cnt <= '0;
              to_cnt     <= '0;
              if (st == S_SETTLE_A) begin
                st          <= S_MOVE_B;
                active_axis <= !axis_a;
              end else begin
                st      <= S_ALIGNED;
                aligned <= 1'b1;
              end
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          S_ALIGNED: begin
            if (!theta_in || !phi_in) begin
              st          <= S_MOVE_A;
              aligned     <= 1'b0;
              active_axis <= axis_a;
              to_cnt      <= '0;
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tracker_axis_sequencer.sv
// ============================================================================
// Module  : tb_tracker_axis_sequencer
// Brief   : Directed vector table plus multi-cycle sequences for the sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tracker_axis_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic        clear_fault;
  logic [15:0] r_v1, r_v2, r_h1, r_h2;
  logic [15:0] theta_target, theta_actual, phi_target, phi_actual;
  logic        theta_pos, theta_neg, phi_pos, phi_neg;
  logic        active_axis, aligned, timeout_err;
  logic [2:0]  state;

  int checks = 0;
  int passed = 0;

  tracker_axis_sequencer #(.W(16), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .clear_fault(clear_fault),
    .r_v1(r_v1), .r_v2(r_v2), .r_h1(r_h1), .r_h2(r_h2),
    .theta_target(theta_target), .theta_actual(theta_actual),
    .phi_target(phi_target), .phi_actual(phi_actual),
    .theta_pos(theta_pos), .theta_neg(theta_neg), .phi_pos(phi_pos), .phi_neg(phi_neg),
    .active_axis(active_axis), .aligned(aligned), .timeout_err(timeout_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] v1, v2, h1, h2;
    logic [15:0] tt, ta, pt, pa;
    logic [7:0]  exp;   // {theta_pos, theta_neg, phi_pos, phi_neg, active_axis, state}
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0; enable = 1'b0; mode = 2'b00; clear_fault = 1'b0;
    r_v1 = 0; r_v2 = 0; r_h1 = 0; r_h2 = 0;
    theta_target = 0; theta_actual = 0; phi_target = 0; phi_actual = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  function automatic logic [7:0] obs();
    return {theta_pos, theta_neg, phi_pos, phi_neg, active_axis, state};
  endfunction

  function automatic logic [3:0] drv();
    return {theta_pos, theta_neg, phi_pos, phi_neg};
  endfunction

  initial begin
    vecs[0]  = '{2'b00, 16'd300, 16'd100, 16'd50, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 8'b1000_0_001};
    vecs[1]  = '{2'b00, 16'd100, 16'd150, 16'd50, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 8'b0100_0_001};
    vecs[2]  = '{2'b00, 16'd105, 16'd100, 16'd50, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 8'b0000_0_010};
    vecs[3]  = '{2'b00, 16'd77,  16'd77,  16'd50, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 8'b0000_0_010};
    vecs[4]  = '{2'b00, 16'd106, 16'd100, 16'd50, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 8'b1000_0_001};
    vecs[5]  = '{2'b00, 16'd0, 16'd65535, 16'd50, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 8'b0100_0_001};
    vecs[6]  = '{2'b00, 16'd65535, 16'd0, 16'd50, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 8'b1000_0_001};
    vecs[7]  = '{2'b11, 16'd100, 16'd300, 16'd50, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 8'b0100_0_001};
    vecs[8]  = '{2'b10, 16'd95,  16'd100, 16'd50, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 8'b0000_0_010};
    vecs[9]  = '{2'b01, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7, 16'd7, 16'd350, 16'd10,  8'b0010_1_001};
    vecs[10] = '{2'b01, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7, 16'd7, 16'd20,  16'd200, 8'b0010_1_001};
    vecs[11] = '{2'b01, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7, 16'd7, 16'd200, 16'd20,  8'b0001_1_001};
    vecs[12] = '{2'b01, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7, 16'd7, 16'd100, 16'd300, 8'b0001_1_001};
    vecs[13] = '{2'b01, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7, 16'd7, 16'd50,  16'd100, 8'b0010_1_001};
    vecs[14] = '{2'b01, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7, 16'd7, 16'd355, 16'd0,   8'b0000_1_010};
    vecs[15] = '{2'b01, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7, 16'd7, 16'd0,   16'd3,   8'b0000_1_010};

    reset_dut();
    check("reset_state", {6'd0, drv(), active_axis, aligned, timeout_err, state}, 16'h0);

    // Vector table: two edges after enable, axis A shows its first move decision.
    for (int i = 0; i < 16; i++) begin
      reset_dut();
      mode = vecs[i].mode;
      r_v1 = vecs[i].v1; r_v2 = vecs[i].v2; r_h1 = vecs[i].h1; r_h2 = vecs[i].h2;
      theta_target = vecs[i].tt; theta_actual = vecs[i].ta;
      phi_target = vecs[i].pt; phi_actual = vecs[i].pa;
      enable = 1'b1;
      tick(); tick();
      check($sformatf("vec%0d", i), {8'd0, obs()}, {8'd0, vecs[i].exp});
    end

    // Automatic theta drive, settle, phi settle, aligned, perturbation.
    begin
      logic ok;
      reset_dut();
      r_v1 = 300; r_v2 = 100; r_h1 = 50; r_h2 = 50; enable = 1'b1;
      tick();
      check("auto_idle_to_move", {13'd0, state}, 16'd1);
      tick();
      check("auto_theta_pos", {12'd0, drv()}, 16'b1000);
      ok = 1'b1;
      repeat (9) begin
        tick();
        if (drv() !== 4'b1000 || state !== 3'd1) ok = 1'b0;
      end
      check("auto_theta_hold", {15'd0, ok}, 16'd1);
      r_v1 = 102;
      tick();
      check("auto_settle_entry", {9'd0, obs()}, {9'd0, 8'b0000_0_010});
      repeat (3) tick();
      check("auto_settle_len", {13'd0, state}, 16'd2);
      tick();
      check("auto_move_b", {12'd0, active_axis, state}, {12'd0, 1'b1, 3'd3});
      tick();
      repeat (3) tick();
      check("auto_settle_b", {13'd0, state}, 16'd4);
      tick();
      check("auto_aligned", {12'd0, aligned, state}, {12'd0, 1'b1, 3'd5});
      r_h1 = 90;
      tick();
      check("perturb_move_a", {11'd0, aligned, active_axis, state}, {11'd0, 1'b0, 1'b0, 3'd1});
      tick();
      check("perturb_theta_settle", {9'd0, obs()}, {9'd0, 8'b0000_0_010});
      repeat (4) tick();
      check("perturb_move_b", {13'd0, state}, 16'd3);
      tick();
      check("perturb_phi_pos", {9'd0, obs()}, {9'd0, 8'b0010_1_011});
    end

    // Reversal dead time.
    reset_dut();
    r_v1 = 300; r_v2 = 100; r_h1 = 50; r_h2 = 50; enable = 1'b1;
    tick(); tick();
    check("rev_pos", {12'd0, drv()}, 16'b1000);
    r_v1 = 50;
    tick();
    check("rev_gap1", {9'd0, obs()}, {9'd0, 8'b0000_0_110});
    tick();
    check("rev_gap2", {9'd0, obs()}, {9'd0, 8'b0000_0_110});
    tick();
    check("rev_neg", {9'd0, obs()}, {9'd0, 8'b0100_0_001});

    // Manual theta timeout with phi already in band.
    begin
      int n;
      logic ok;
      reset_dut();
      mode = 2'b01; theta_actual = 200; theta_target = 100;
      phi_actual = 30; phi_target = 30; enable = 1'b1;
      n = 0;
      while (state !== 3'd3 && n < 30) begin
        tick();
        n++;
      end
      check("to_reach_move_b", {13'd0, state}, 16'd3);
      tick();
      check("to_theta_pos", {12'd0, drv()}, 16'b1000);
      ok = 1'b1;
      repeat (18) begin
        tick();
        if (state !== 3'd3) ok = 1'b0;
      end
      check("to_move_len", {15'd0, ok}, 16'd1);
      tick();
      check("to_fault", {8'd0, drv(), timeout_err, state}, {8'd0, 4'b0000, 1'b1, 3'd7});
      enable = 1'b0; mode = 2'b00;
      repeat (3) tick();
      check("fault_hold", {8'd0, drv(), timeout_err, state}, {8'd0, 4'b0000, 1'b1, 3'd7});
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      check("fault_clear", {12'd0, timeout_err, state}, 16'd0);
    end

    // Asynchronous reset while phi drives neg.
    begin
      int n;
      reset_dut();
      r_v1 = 100; r_v2 = 100; r_h1 = 100; r_h2 = 200; enable = 1'b1;
      n = 0;
      while (phi_neg !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      check("ar_phi_neg", {9'd0, obs()}, {9'd0, 8'b0001_1_011});
      #3 rst = 1'b0;
      #1;
      check("ar_immediate", {9'd0, obs()}, 16'd0);
      tick();
      check("ar_held", {12'd0, drv()}, 16'd0);
      rst = 1'b1;
    end

    // Mode change mid-move, then enable drop.
    reset_dut();
    r_v1 = 300; r_v2 = 100; r_h1 = 50; r_h2 = 50;
    phi_actual = 10; phi_target = 350; enable = 1'b1;
    tick(); tick();
    check("mc_theta_pos", {12'd0, drv()}, 16'b1000);
    mode = 2'b01;
    tick();
    check("mc_idle_cycle", {9'd0, obs()}, {9'd0, 8'b0000_1_001});
    tick();
    check("mc_phi_pos", {9'd0, obs()}, {9'd0, 8'b0010_1_001});
    enable = 1'b0;
    tick();
    check("en_drop", {9'd0, drv(), state}, 16'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
